// File: rtl/umstr_ethii_demux_if.sv
// Signal bundle between the RX Ethernet II header parser, the EtherType demux
// and the ARP/IPv4 receive consumers. The slave modport is the demux side.
interface umstr_ethii_demux_if #(
  parameter int CNT_W = 16
);
  logic [47:0]      local_mac_i;
  logic [47:0]      hdr_mac_dest_i;
  logic [47:0]      hdr_mac_src_i;
  logic [15:0]      hdr_mac_type_i;
  logic             hdr_mac_vld_i;
  logic             hdr_mac_rdy_o;
  logic [31:0]      user_tdata_i;
  logic             user_tvld_i;
  logic             user_tlast_i;
  logic [3:0]       user_tkeep_i;
  logic             user_trdy_o;
  logic [47:0]      arp_mac_dest_o;
  logic [47:0]      arp_mac_src_o;
  logic [15:0]      arp_mac_type_o;
  logic             arp_mac_vld_o;
  logic             arp_mac_rdy_i;
  logic [31:0]      arp_tdata_o;
  logic             arp_tvld_o;
  logic             arp_tlast_o;
  logic [3:0]       arp_tkeep_o;
  logic             arp_trdy_i;
  logic [47:0]      ipv4_mac_dest_o;
  logic [47:0]      ipv4_mac_src_o;
  logic [15:0]      ipv4_mac_type_o;
  logic             ipv4_mac_vld_o;
  logic             ipv4_mac_rdy_i;
  logic [31:0]      ipv4_tdata_o;
  logic             ipv4_tvld_o;
  logic             ipv4_tlast_o;
  logic [3:0]       ipv4_tkeep_o;
  logic             ipv4_trdy_i;
  logic [CNT_W-1:0] drop_cnt_o;

  modport slave (
    input  local_mac_i, hdr_mac_dest_i, hdr_mac_src_i, hdr_mac_type_i, hdr_mac_vld_i,
    input  user_tdata_i, user_tvld_i, user_tlast_i, user_tkeep_i,
    input  arp_mac_rdy_i, arp_trdy_i, ipv4_mac_rdy_i, ipv4_trdy_i,
    output hdr_mac_rdy_o, user_trdy_o,
    output arp_mac_dest_o, arp_mac_src_o, arp_mac_type_o, arp_mac_vld_o,
    output arp_tdata_o, arp_tvld_o, arp_tlast_o, arp_tkeep_o,
    output ipv4_mac_dest_o, ipv4_mac_src_o, ipv4_mac_type_o, ipv4_mac_vld_o,
    output ipv4_tdata_o, ipv4_tvld_o, ipv4_tlast_o, ipv4_tkeep_o,
    output drop_cnt_o
  );

  modport master (
    output local_mac_i, hdr_mac_dest_i, hdr_mac_src_i, hdr_mac_type_i, hdr_mac_vld_i,
    output user_tdata_i, user_tvld_i, user_tlast_i, user_tkeep_i,
    output arp_mac_rdy_i, arp_trdy_i, ipv4_mac_rdy_i, ipv4_trdy_i,
    input  hdr_mac_rdy_o, user_trdy_o,
    input  arp_mac_dest_o, arp_mac_src_o, arp_mac_type_o, arp_mac_vld_o,
    input  arp_tdata_o, arp_tvld_o, arp_tlast_o, arp_tkeep_o,
    input  ipv4_mac_dest_o, ipv4_mac_src_o, ipv4_mac_type_o, ipv4_mac_vld_o,
    input  ipv4_tdata_o, ipv4_tvld_o, ipv4_tlast_o, ipv4_tkeep_o,
    input  drop_cnt_o
  );
endinterface

// File: rtl/umstr_ethii_demux.sv
// Ethernet II receive demux: filters on destination MAC and routes each frame
// by EtherType to the ARP or IPv4 consumer; everything else is dropped and counted.
module umstr_ethii_demux #(
  parameter logic [15:0] ETH_TYPE_ARP  = 16'h0806,
  parameter logic [15:0] ETH_TYPE_IPV4 = 16'h0800,
  parameter bit          MAC_FILTER_EN = 1'b1,
  parameter int          CNT_W         = 16
) (
  input logic                clk,
  input logic                reset_n,
  umstr_ethii_demux_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_SEND_MAC_ARP  = 3'd1,
    S_SEND_PLD_ARP  = 3'd2,
    S_SEND_MAC_IPV4 = 3'd3,
    S_SEND_PLD_IPV4 = 3'd4,
    S_DROP          = 3'd5
  } state_t;

  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_hdr_rdy;
  logic             w_user_trdy;
  logic             w_dest_match;
  logic             w_is_arp;
  logic             w_is_ipv4;
  logic             w_hdr_acc;
  logic             w_pld_rdy_arp;
  logic             w_pld_rdy_ipv4;
  logic             w_load_arp;
  logic             w_load_ipv4;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [47:0] r_arp_dest, r_arp_src, r_ipv4_dest, r_ipv4_src;
  logic [15:0] r_arp_type, r_ipv4_type;
  logic [31:0] r_arp_tdata, r_ipv4_tdata;
  logic [3:0]  r_arp_tkeep, r_ipv4_tkeep;
  logic        r_arp_tlast, r_ipv4_tlast, r_arp_tvld, r_ipv4_tvld;

  assign w_dest_match = !MAC_FILTER_EN
                     || (bus.hdr_mac_dest_i == bus.local_mac_i)
                     || (bus.hdr_mac_dest_i == MAC_BCAST);
  assign w_is_arp     = w_dest_match && (bus.hdr_mac_type_i == ETH_TYPE_ARP);
  assign w_is_ipv4    = w_dest_match && (bus.hdr_mac_type_i == ETH_TYPE_IPV4);
  assign w_hdr_acc    = (r_state == S_IDLE) && bus.hdr_mac_vld_i;

  // An output register can take a new beat when empty or being emptied this cycle.
  assign w_pld_rdy_arp  = !r_arp_tvld  || bus.arp_trdy_i;
  assign w_pld_rdy_ipv4 = !r_ipv4_tvld || bus.ipv4_trdy_i;
  assign w_load_arp     = (r_state == S_SEND_PLD_ARP)  && bus.user_tvld_i && w_pld_rdy_arp;
  assign w_load_ipv4    = (r_state == S_SEND_PLD_IPV4) && bus.user_tvld_i && w_pld_rdy_ipv4;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_hdr_rdy   = 1'b0;
    w_user_trdy = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_hdr_rdy = 1'b1;
        if (bus.hdr_mac_vld_i) begin
          if (w_is_arp)       w_state_nxt = S_SEND_MAC_ARP;
          else if (w_is_ipv4) w_state_nxt = S_SEND_MAC_IPV4;
          else                w_state_nxt = S_DROP;
        end
      end
      S_SEND_MAC_ARP:  if (bus.arp_mac_rdy_i)  w_state_nxt = S_SEND_PLD_ARP;
      S_SEND_MAC_IPV4: if (bus.ipv4_mac_rdy_i) w_state_nxt = S_SEND_PLD_IPV4;
      S_SEND_PLD_ARP: begin
        w_user_trdy = w_pld_rdy_arp;
        if (w_load_arp && bus.user_tlast_i) w_state_nxt = S_IDLE;
      end
      S_SEND_PLD_IPV4: begin
        w_user_trdy = w_pld_rdy_ipv4;
        if (w_load_ipv4 && bus.user_tlast_i) w_state_nxt = S_IDLE;
      end
      S_DROP: begin
        w_user_trdy = 1'b1;
        if (bus.user_tvld_i && bus.user_tlast_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: header and data registers are reset too, because their values are
  // visible on the ports and must read as zero after reset, not just be ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arp_dest  <= '0;
      r_arp_src   <= '0;
      r_arp_type  <= '0;
      r_ipv4_dest <= '0;
      r_ipv4_src  <= '0;
      r_ipv4_type <= '0;
    end else if (w_hdr_acc) begin
      if (w_is_arp) begin
        r_arp_dest <= bus.hdr_mac_dest_i;
        r_arp_src  <= bus.hdr_mac_src_i;
        r_arp_type <= bus.hdr_mac_type_i;
      end
      if (w_is_ipv4) begin
        r_ipv4_dest <= bus.hdr_mac_dest_i;
        r_ipv4_src  <= bus.hdr_mac_src_i;
        r_ipv4_type <= bus.hdr_mac_type_i;
      end
    end
  end

  // Output stages drain on their own, independent of the FSM state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arp_tdata <= '0;
      r_arp_tkeep <= '0;
      r_arp_tlast <= 1'b0;
      r_arp_tvld  <= 1'b0;
    end else if (w_load_arp) begin
      r_arp_tdata <= bus.user_tdata_i;
      r_arp_tkeep <= bus.user_tkeep_i;
      r_arp_tlast <= bus.user_tlast_i;
      r_arp_tvld  <= 1'b1;
    end else if (bus.arp_trdy_i) begin
      r_arp_tvld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ipv4_tdata <= '0;
      r_ipv4_tkeep <= '0;
      r_ipv4_tlast <= 1'b0;
      r_ipv4_tvld  <= 1'b0;
    end else if (w_load_ipv4) begin
      r_ipv4_tdata <= bus.user_tdata_i;
      r_ipv4_tkeep <= bus.user_tkeep_i;
      r_ipv4_tlast <= bus.user_tlast_i;
      r_ipv4_tvld  <= 1'b1;
    end else if (bus.ipv4_trdy_i) begin
      r_ipv4_tvld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_drop_cnt <= '0;
    else if (w_hdr_acc && !w_is_arp && !w_is_ipv4 && (r_drop_cnt != '1))
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
  end

  assign bus.hdr_mac_rdy_o   = w_hdr_rdy;
  assign bus.user_trdy_o     = w_user_trdy;
  assign bus.arp_mac_vld_o   = (r_state == S_SEND_MAC_ARP);
  assign bus.ipv4_mac_vld_o  = (r_state == S_SEND_MAC_IPV4);
  assign bus.arp_mac_dest_o  = r_arp_dest;
  assign bus.arp_mac_src_o   = r_arp_src;
  assign bus.arp_mac_type_o  = r_arp_type;
  assign bus.ipv4_mac_dest_o = r_ipv4_dest;
  assign bus.ipv4_mac_src_o  = r_ipv4_src;
  assign bus.ipv4_mac_type_o = r_ipv4_type;
  assign bus.arp_tdata_o     = r_arp_tdata;
  assign bus.arp_tkeep_o     = r_arp_tkeep;
  assign bus.arp_tlast_o     = r_arp_tlast;
  assign bus.arp_tvld_o      = r_arp_tvld;
  assign bus.ipv4_tdata_o    = r_ipv4_tdata;
  assign bus.ipv4_tkeep_o    = r_ipv4_tkeep;
  assign bus.ipv4_tlast_o    = r_ipv4_tlast;
  assign bus.ipv4_tvld_o     = r_ipv4_tvld;
  assign bus.drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_umstr_ethii_demux.sv
// Randomized bench for umstr_ethii_demux: frames are routed by a queue-based
// reference model and every delivered header/beat is scored against it.
module tb_umstr_ethii_demux;

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

  typedef struct packed { logic [47:0] dest; logic [47:0] src; logic [15:0] typ; } hdr_t;
  typedef struct packed { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus shared by both DUTs; sel picks which one sees valids and is observed.
  logic        sel = 1'b0;
  logic        bp = 1'b0;
  hdr_t        hdr_in;
  logic        hdr_vld = 1'b0;
  beat_t       beat_in;
  logic        u_vld = 1'b0;
  logic        arp_mac_rdy = 1'b1, arp_trdy = 1'b1, ipv4_mac_rdy = 1'b1, ipv4_trdy = 1'b1;

  umstr_ethii_demux_if #(.CNT_W(16)) if0 ();
  umstr_ethii_demux_if #(.CNT_W(2))  if1 ();

  umstr_ethii_demux #(.MAC_FILTER_EN(1'b1), .CNT_W(16)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  umstr_ethii_demux #(.MAC_FILTER_EN(1'b0), .CNT_W(2))  dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

  assign if0.local_mac_i    = LOCAL_MAC;
  assign if0.hdr_mac_dest_i = hdr_in.dest;
  assign if0.hdr_mac_src_i  = hdr_in.src;
  assign if0.hdr_mac_type_i = hdr_in.typ;
  assign if0.hdr_mac_vld_i  = hdr_vld && !sel;
  assign if0.user_tdata_i   = beat_in.data;
  assign if0.user_tkeep_i   = beat_in.keep;
  assign if0.user_tlast_i   = beat_in.last;
  assign if0.user_tvld_i    = u_vld && !sel;
  assign if0.arp_mac_rdy_i  = arp_mac_rdy;
  assign if0.arp_trdy_i     = arp_trdy;
  assign if0.ipv4_mac_rdy_i = ipv4_mac_rdy;
  assign if0.ipv4_trdy_i    = ipv4_trdy;

  assign if1.local_mac_i    = LOCAL_MAC;
  assign if1.hdr_mac_dest_i = hdr_in.dest;
  assign if1.hdr_mac_src_i  = hdr_in.src;
  assign if1.hdr_mac_type_i = hdr_in.typ;
  assign if1.hdr_mac_vld_i  = hdr_vld && sel;
  assign if1.user_tdata_i   = beat_in.data;
  assign if1.user_tkeep_i   = beat_in.keep;
  assign if1.user_tlast_i   = beat_in.last;
  assign if1.user_tvld_i    = u_vld && sel;
  assign if1.arp_mac_rdy_i  = arp_mac_rdy;
  assign if1.arp_trdy_i     = arp_trdy;
  assign if1.ipv4_mac_rdy_i = ipv4_mac_rdy;
  assign if1.ipv4_trdy_i    = ipv4_trdy;

  logic        w_hdr_rdy, w_user_trdy, w_arp_mac_vld, w_ipv4_mac_vld, w_arp_tvld, w_ipv4_tvld;
  hdr_t        w_arp_hdr, w_ipv4_hdr;
  beat_t       w_arp_beat, w_ipv4_beat;
  logic [15:0] w_drop_cnt;

  assign w_hdr_rdy      = sel ? if1.hdr_mac_rdy_o  : if0.hdr_mac_rdy_o;
  assign w_user_trdy    = sel ? if1.user_trdy_o    : if0.user_trdy_o;
  assign w_arp_mac_vld  = sel ? if1.arp_mac_vld_o  : if0.arp_mac_vld_o;
  assign w_ipv4_mac_vld = sel ? if1.ipv4_mac_vld_o : if0.ipv4_mac_vld_o;
  assign w_arp_tvld     = sel ? if1.arp_tvld_o     : if0.arp_tvld_o;
  assign w_ipv4_tvld    = sel ? if1.ipv4_tvld_o    : if0.ipv4_tvld_o;
  assign w_arp_hdr  = sel ? {if1.arp_mac_dest_o, if1.arp_mac_src_o, if1.arp_mac_type_o}
                          : {if0.arp_mac_dest_o, if0.arp_mac_src_o, if0.arp_mac_type_o};
  assign w_ipv4_hdr = sel ? {if1.ipv4_mac_dest_o, if1.ipv4_mac_src_o, if1.ipv4_mac_type_o}
                          : {if0.ipv4_mac_dest_o, if0.ipv4_mac_src_o, if0.ipv4_mac_type_o};
  assign w_arp_beat  = sel ? {if1.arp_tdata_o, if1.arp_tkeep_o, if1.arp_tlast_o}
                           : {if0.arp_tdata_o, if0.arp_tkeep_o, if0.arp_tlast_o};
  assign w_ipv4_beat = sel ? {if1.ipv4_tdata_o, if1.ipv4_tkeep_o, if1.ipv4_tlast_o}
                           : {if0.ipv4_tdata_o, if0.ipv4_tkeep_o, if0.ipv4_tlast_o};
  assign w_drop_cnt  = sel ? {14'd0, if1.drop_cnt_o} : if0.drop_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected deliveries per port and drop count per DUT.
  hdr_t  exp_hdr_arp[$], exp_hdr_ipv4[$];
  beat_t exp_beat_arp[$], exp_beat_ipv4[$];
  int    exp_drop[2] = '{0, 0};
  int    last_tlast_cyc = 0;
  int    last_gap = 0;

  function automatic int route(input hdr_t h, input bit filt);
    bit match;
    match = !filt || (h.dest == LOCAL_MAC) || (h.dest == BCAST);
    if (match && h.typ == 16'h0806) return 1;
    if (match && h.typ == 16'h0800) return 2;
    return 0;
  endfunction

  // Scoreboard: compare every downstream handshake against the model queues.
  logic  r_arp_stall = 1'b0, r_ipv4_stall = 1'b0;
  beat_t r_arp_prev, r_ipv4_prev;

  always @(negedge clk) begin
    if (reset_n) begin
      if (w_arp_mac_vld && arp_mac_rdy) begin
        if (exp_hdr_arp.size() == 0) check("arp_hdr_extra", 1, 0);
        else check("arp_hdr", w_arp_hdr, exp_hdr_arp.pop_front());
      end
      if (w_ipv4_mac_vld && ipv4_mac_rdy) begin
        if (exp_hdr_ipv4.size() == 0) check("ipv4_hdr_extra", 1, 0);
        else check("ipv4_hdr", w_ipv4_hdr, exp_hdr_ipv4.pop_front());
      end
      if (r_arp_stall)  check("arp_hold",  {w_arp_tvld, w_arp_beat},   {1'b1, r_arp_prev});
      if (r_ipv4_stall) check("ipv4_hold", {w_ipv4_tvld, w_ipv4_beat}, {1'b1, r_ipv4_prev});
      if (w_arp_tvld && arp_trdy) begin
        if (exp_beat_arp.size() == 0) check("arp_beat_extra", 1, 0);
        else check("arp_beat", w_arp_beat, exp_beat_arp.pop_front());
      end
      if (w_ipv4_tvld && ipv4_trdy) begin
        if (exp_beat_ipv4.size() == 0) check("ipv4_beat_extra", 1, 0);
        else check("ipv4_beat", w_ipv4_beat, exp_beat_ipv4.pop_front());
      end
      r_arp_stall  <= w_arp_tvld && !arp_trdy;
      r_ipv4_stall <= w_ipv4_tvld && !ipv4_trdy;
      r_arp_prev   <= w_arp_beat;
      r_ipv4_prev  <= w_ipv4_beat;
    end else begin
      r_arp_stall  <= 1'b0;
      r_ipv4_stall <= 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      arp_mac_rdy  = bp ? 1'($urandom_range(1)) : 1'b1;
      arp_trdy     = bp ? 1'($urandom_range(1)) : 1'b1;
      ipv4_mac_rdy = bp ? 1'($urandom_range(1)) : 1'b1;
      ipv4_trdy    = bp ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_frame(input hdr_t h, input int nbeats, input logic [3:0] last_keep, input int abort_at);
    int    r;
    int    guard;
    beat_t b;
    r = route(h, !sel);
    if (r == 0)      exp_drop[sel] = (exp_drop[sel] == (sel ? 3 : 65535)) ? exp_drop[sel] : exp_drop[sel] + 1;
    else if (r == 1) exp_hdr_arp.push_back(h);
    else             exp_hdr_ipv4.push_back(h);
    hdr_in  = h;
    hdr_vld = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!w_hdr_rdy && guard < 100);
    check("hdr_accept", w_hdr_rdy, 1);
    last_gap = cyc - last_tlast_cyc;
    @(posedge clk); #1;
    hdr_vld = 1'b0;
    hdr_in  = {48'($urandom), 48'($urandom), 16'($urandom)};
    @(negedge clk);
    check("arp_mac_vld_lat",  w_arp_mac_vld,  r == 1);
    check("ipv4_mac_vld_lat", w_ipv4_mac_vld, r == 2);
    @(posedge clk); #1;
    for (int i = 0; i < nbeats; i++) begin
      b.data = $urandom;
      b.keep = (i == nbeats - 1) ? last_keep : 4'hF;
      b.last = (i == nbeats - 1);
      if (bp && $urandom_range(3) == 0) begin
        u_vld = 1'b0;
        @(posedge clk); #1;
      end
      beat_in = b;
      u_vld   = 1'b1;
      if (i == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_vld", {w_arp_mac_vld, w_ipv4_mac_vld, w_arp_tvld, w_ipv4_tvld}, 0);
        check("rst_drop", w_drop_cnt, 0);
        exp_hdr_arp.delete(); exp_hdr_ipv4.delete();
        exp_beat_arp.delete(); exp_beat_ipv4.delete();
        exp_drop = '{0, 0};
        u_vld = 1'b0;
        return;
      end
      guard = 0;
      do begin @(negedge clk); guard++; end while (!w_user_trdy && guard < 200);
      check("user_trdy", w_user_trdy, 1);
      if (r == 0) check("drop_trdy_imm", guard, 1);
      if (i == 0) check("hdr_rdy_busy", w_hdr_rdy, 0);
      if (r == 1) exp_beat_arp.push_back(b);
      if (r == 2) exp_beat_ipv4.push_back(b);
      if (b.last) last_tlast_cyc = cyc;
      @(posedge clk); #1;
    end
    u_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    do begin @(negedge clk); guard++; end
    while ((exp_hdr_arp.size() + exp_hdr_ipv4.size() + exp_beat_arp.size() + exp_beat_ipv4.size() != 0
            || w_arp_tvld || w_ipv4_tvld || w_arp_mac_vld || w_ipv4_mac_vld) && guard < 500);
    check("drain", exp_hdr_arp.size() + exp_hdr_ipv4.size() + exp_beat_arp.size() + exp_beat_ipv4.size(), 0);
    check("drop_cnt", w_drop_cnt, exp_drop[sel]);
    @(posedge clk); #1;
  endtask

  function automatic hdr_t rand_hdr();
    hdr_t h;
    case ($urandom_range(2))
      0:       h.dest = LOCAL_MAC;
      1:       h.dest = BCAST;
      default: h.dest = {16'h0A00, 32'($urandom)};
    endcase
    case ($urandom_range(3))
      0:       h.typ = 16'h0806;
      1:       h.typ = 16'h0800;
      2:       h.typ = 16'h86DD;
      default: h.typ = 16'($urandom);
    endcase
    h.src = {16'h0B00, 32'($urandom)};
    return h;
  endfunction

  initial begin
    logic [3:0] keeps [4] = '{4'h1, 4'h3, 4'h7, 4'hF};
    hdr_in  = '0;
    beat_in = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", {w_arp_mac_vld, w_ipv4_mac_vld, w_arp_tvld, w_ipv4_tvld, w_arp_beat, w_ipv4_beat}, 0);
    check("rst_hdr_regs", {w_arp_hdr, w_ipv4_hdr}, 0);
    check("rst_drop0", w_drop_cnt, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_hdr_rdy", w_hdr_rdy, 1);
    check("idle_user_trdy", w_user_trdy, 0);
    @(posedge clk); #1;

    // ARP broadcast, 7 beats, last keep 3
    send_frame('{dest: BCAST, src: 48'h0200_0000_0042, typ: 16'h0806}, 7, 4'h3, -1);
    wait_drain();

    // Filtered unicast dropped on the filtering DUT, routed on the open one
    send_frame('{dest: 48'h02_00_00_00_00_99, src: 48'h0200_0000_0042, typ: 16'h0800}, 4, 4'hF, -1);
    wait_drain();
    check("filter_drop1", w_drop_cnt, 1);
    sel = 1'b1;
    send_frame('{dest: 48'h02_00_00_00_00_99, src: 48'h0200_0000_0042, typ: 16'h0800}, 4, 4'hF, -1);
    wait_drain();
    sel = 1'b0;

    // IPv4 unicast with random back-pressure
    bp = 1'b1;
    for (int f = 0; f < 6; f++)
      send_frame('{dest: LOCAL_MAC, src: {16'h0B00, 32'($urandom)}, typ: 16'h0800},
                 $urandom_range(8, 1), keeps[$urandom_range(3)], -1);
    wait_drain();
    bp = 1'b0;
    @(posedge clk); #1;

    // Back-to-back single-beat frames: unknown, ARP, IPv4
    send_frame('{dest: LOCAL_MAC, src: 48'h1, typ: 16'h86DD}, 1, 4'h1, -1);
    send_frame('{dest: LOCAL_MAC, src: 48'h2, typ: 16'h0806}, 1, 4'h3, -1);
    check("b2b_gap_arp", last_gap, 1);
    send_frame('{dest: LOCAL_MAC, src: 48'h3, typ: 16'h0800}, 1, 4'h7, -1);
    check("b2b_gap_ipv4", last_gap, 1);
    wait_drain();

    // Random mixed traffic with back-pressure
    bp = 1'b1;
    for (int f = 0; f < 20; f++)
      send_frame(rand_hdr(), $urandom_range(8, 1), keeps[$urandom_range(3)], -1);
    wait_drain();
    bp = 1'b0;
    @(posedge clk); #1;

    // Saturation on the 2-bit counter
    sel = 1'b1;
    for (int f = 0; f < 5; f++)
      send_frame('{dest: BCAST, src: 48'h5, typ: 16'h86DD}, 2, 4'hF, -1);
    wait_drain();
    check("drop_sat", w_drop_cnt, 3);
    sel = 1'b0;

    // Reset in the middle of an IPv4 frame, then a fresh ARP frame
    send_frame('{dest: LOCAL_MAC, src: 48'h6, typ: 16'h0800}, 6, 4'hF, 2);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    send_frame('{dest: BCAST, src: 48'h7, typ: 16'h0806}, 3, 4'h7, -1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
